// File: rtl/misp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : misp_pkg                                                     |
// | Description : Shared types and constants for the MISP data-memory path:   |
// |               responder FSM state encoding, data word width and the       |
// |               width of the responder wait counter.                        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package misp_pkg;

  localparam int MISP_WORD_W = 32;

  // Wait counter holds LATENCY-2, so 3 bits cover the full LATENCY range 1..8.
  localparam int MISP_CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } misp_dmem_state_e;

endpackage : misp_pkg
`default_nettype wire

// File: rtl/misp_dmem_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : misp_dmem_array                                              |
// | Description : Synchronous single-port word RAM with byte-lane write       |
// |               enables and a registered read port. Contents are not reset. |
// | Ports       : clk   - rising-edge clock                                    |
// |               en    - access enable for this edge                          |
// |               we    - 1 = write enabled lanes, 0 = read word into rdata    |
// |               be    - byte-lane enables, bit i covers bits [8i+7:8i]       |
// |               addr  - word index                                           |
// |               wdata - write data                                           |
// |               rdata - registered read data (updated only by reads)         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module misp_dmem_array
  import misp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic                   clk,
  input  logic                   en,
  input  logic                   we,
  input  logic [3:0]             be,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [MISP_WORD_W-1:0] wdata,
  output logic [MISP_WORD_W-1:0] rdata
);

  logic [MISP_WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [MISP_WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) begin
            mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule : misp_dmem_array
`default_nettype wire

// File: rtl/misp_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : misp_dmem_responder                                          |
// | Description : MEM-stage data-memory responder. Accepts one load/store at  |
// |               a time over valid/ready, accesses the word RAM after a      |
// |               fixed number of wait cycles and returns a one-cycle         |
// |               response. busy is high whenever the FSM is not IDLE.        |
// | Ports       : clk, reset (async, active-low)                               |
// |               req_valid/req_ready/req_write/req_addr/req_wdata/req_be      |
// |               rsp_valid/rsp_rdata/rsp_err, busy                            |
// | Options     : MISP_DMEM_ERRCHK_EN - when defined, misaligned and          |
// |               out-of-range accesses are flagged on rsp_err and never      |
// |               touch the array; when undefined the index simply wraps.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module misp_dmem_responder
  import misp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [31:0]            req_addr,
  input  logic [MISP_WORD_W-1:0] req_wdata,
  input  logic [3:0]             req_be,
  output logic                   rsp_valid,
  output logic [MISP_WORD_W-1:0] rsp_rdata,
  output logic                   rsp_err,
  output logic                   busy
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [MISP_CNT_W-1:0] CNT_INIT =
      (LATENCY > 1) ? MISP_CNT_W'(LATENCY - 2) : '0;

  misp_dmem_state_e       state_q, state_d;
  logic [MISP_CNT_W-1:0]  cnt_q, cnt_d;

  // Request captured on the accept edge; the requester may change req_* after.
  logic                   wr_q;
  logic [IDX_W-1:0]       idx_q;
  logic [MISP_WORD_W-1:0] wdata_q;
  logic [3:0]             be_q;
  logic                   err_q;

  // Last response, held between RESP cycles.
  logic [MISP_WORD_W-1:0] rdata_hold_q;
  logic                   err_hold_q;

  logic [31:0]            w_off;
  logic [IDX_W-1:0]       w_idx;
  logic                   w_err;
  logic                   w_accept;

  logic                   w_arr_en;
  logic                   w_arr_we;
  logic [3:0]             w_arr_be;
  logic [IDX_W-1:0]       w_arr_addr;
  logic [MISP_WORD_W-1:0] w_arr_wdata;
  logic [MISP_WORD_W-1:0] w_arr_rdata;
  logic [MISP_WORD_W-1:0] w_rsp_rdata;

  // -------------------------------------------------------------------------
  // Address decode and error check
  // -------------------------------------------------------------------------
  assign w_off = req_addr - BASE_ADDR;
  assign w_idx = w_off[IDX_W+1:2];

`ifdef MISP_DMEM_ERRCHK_EN
  // Any bit of (offset >> 2) above the index width means index >= DEPTH_WORDS.
  assign w_err = (req_addr[1:0] != 2'b00) ||
                 (req_addr < BASE_ADDR)   ||
                 (w_off[31:IDX_W+2] != '0);
`else
  logic w_unused_off_bits;
  assign w_unused_off_bits = ^{w_off[31:IDX_W+2], w_off[1:0]};
  assign w_err = 1'b0;
`endif

  assign w_accept = (state_q == S_IDLE) && req_valid;

  // -------------------------------------------------------------------------
  // FSM: next state and wait counter
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = (LATENCY > 1) ? S_WAIT : S_RESP;
          cnt_d   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - MISP_CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Request capture
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
    end else if (w_accept) begin
      wr_q    <= req_write;
      idx_q   <= w_idx;
      wdata_q <= req_wdata;
      be_q    <= req_be;
      err_q   <= w_err;
    end
  end

  // -------------------------------------------------------------------------
  // Array access. With LATENCY=1 the access edge is the accept edge, so the
  // array is driven straight from the request; otherwise it is driven from
  // the captured request on the edge that leaves WAIT. Gating with reset keeps
  // a held request from reaching the array while reset is asserted.
  // -------------------------------------------------------------------------
  always_comb begin
    if (LATENCY == 1) begin
      w_arr_en    = w_accept;
      w_arr_we    = req_write & ~w_err;
      w_arr_be    = req_be;
      w_arr_addr  = w_idx;
      w_arr_wdata = req_wdata;
    end else begin
      w_arr_en    = (state_q == S_WAIT) && (cnt_q == '0);
      w_arr_we    = wr_q & ~err_q;
      w_arr_be    = be_q;
      w_arr_addr  = idx_q;
      w_arr_wdata = wdata_q;
    end
    w_arr_en = w_arr_en & reset;
  end

  misp_dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (IDX_W)
  ) u_array (
    .clk   (clk),
    .en    (w_arr_en),
    .we    (w_arr_we),
    .be    (w_arr_be),
    .addr  (w_arr_addr),
    .wdata (w_arr_wdata),
    .rdata (w_arr_rdata)
  );

  // -------------------------------------------------------------------------
  // Response. The array read register supplies the data in RESP; the hold
  // registers keep it visible afterwards. Both mux inputs and the select are
  // flop outputs, so the response pins are glitch-free.
  // -------------------------------------------------------------------------
  assign w_rsp_rdata = (wr_q || err_q) ? '0 : w_arr_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_hold_q <= '0;
      err_hold_q   <= 1'b0;
    end else if (state_q == S_RESP) begin
      rdata_hold_q <= w_rsp_rdata;
      err_hold_q   <= err_q;
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = (state_q == S_RESP) ? w_rsp_rdata : rdata_hold_q;
  assign rsp_err   = (state_q == S_RESP) ? err_q : err_hold_q;
  assign req_ready = (state_q == S_IDLE) && reset;
  assign busy      = (state_q != S_IDLE);

endmodule : misp_dmem_responder
`default_nettype wire
